// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the UART response arbiter: FSM state encodings and source IDs.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_RD  = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_RD : SRC_ALU;
  endfunction

endpackage

// File: rtl/resp_slot.sv
// One-deep capture buffer: holds one response until granted, flags drops when full.
module resp_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             pend_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             free;

  // A slot being granted this cycle counts as free, so a same-cycle strobe is kept.
  assign free = !pend_q || clr_i;

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (vld_i && free) begin
      data_d = data_i;
      pend_d = 1'b1;
    end else begin
      if (clr_i) pend_d = 1'b0;
      if (vld_i) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter serialising ALU (two-byte) and register-read (one-byte) responses to the UART TX.
module tx_resp_arbiter
  import tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter bit          ALU_FIRST    = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ALU_OUT_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    RdData_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    Busy,
  output logic [DATA_WIDTH-1:0]   TX_P_Data,
  output logic                    TX_D_VLD,
  output logic                    CLK_div_en,
  output logic                    ALU_PEND,
  output logic                    RD_PEND,
  output logic                    OVF_ALU,
  output logic                    OVF_RD,
  output logic                    TX_DONE
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned SW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e          state_q, state_d;
  src_e               prio_q, prio_d;
  logic [SW-1:0]      shift_q, shift_d;
  logic               upper_q, upper_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      tx_data_q, tx_data_d;
  logic               tx_vld_q, tx_vld_d;
  logic               tx_done_q, tx_done_d;
  logic               grant_alu, grant_rd;
  logic [SW-1:0]      alu_data;
  logic [DW-1:0]      rd_data;

  resp_slot #(.WIDTH(SW)) u_alu_slot (
    .clk    (CLK),
    .rst    (RST),
    .vld_i  (ALU_OUT_VLD),
    .data_i (ALU_OUT),
    .clr_i  (grant_alu),
    .data_o (alu_data),
    .pend_o (ALU_PEND),
    .ovf_o  (OVF_ALU)
  );

  resp_slot #(.WIDTH(DW)) u_rd_slot (
    .clk    (CLK),
    .rst    (RST),
    .vld_i  (RdData_VLD),
    .data_i (RdData),
    .clr_i  (grant_rd),
    .data_o (rd_data),
    .pend_o (RD_PEND),
    .ovf_o  (OVF_RD)
  );

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    shift_d   = shift_q;
    upper_d   = upper_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    tx_done_d = 1'b0;
    grant_alu = 1'b0;
    grant_rd  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Priority only matters (and only rotates) when both slots contend.
        if (ALU_PEND && (!RD_PEND || prio_q == SRC_ALU)) grant_alu = 1'b1;
        else if (RD_PEND)                                grant_rd  = 1'b1;
        if (ALU_PEND && RD_PEND) prio_d = other_src(prio_q);
        if (grant_alu) begin
          shift_d = alu_data;
          upper_d = 1'b1;
          state_d = LOAD;
        end else if (grant_rd) begin
          shift_d = {DW'(0), rd_data};
          upper_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = shift_q[DW-1:0];
        tx_vld_d  = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        // UART never acknowledged: re-issue the same byte after the timeout.
        if (Busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = LOAD;
        end else if (cnt_q != CNT_W'(BUSY_TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!Busy) begin
          if (upper_q) begin
            shift_d = {DW'(0), shift_q[SW-1:DW]};
            upper_d = 1'b0;
            state_d = LOAD;
          end else begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      prio_q    <= ALU_FIRST ? SRC_ALU : SRC_RD;
      shift_q   <= '0;
      upper_q   <= 1'b0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      shift_q   <= shift_d;
      upper_q   <= upper_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign TX_P_Data  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign TX_DONE    = tx_done_q;
  assign CLK_div_en = RST || (state_q != IDLE) || ALU_PEND || RD_PEND;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed bench for tx_resp_arbiter with a simple UART Busy model and byte monitor.
module tb_tx_resp_arbiter;

  localparam int unsigned DW       = 8;
  localparam int unsigned BT       = 4;
  localparam int          BUSY_LEN = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ALU_OUT_VLD;
  logic [15:0]   ALU_OUT;
  logic          RdData_VLD;
  logic [7:0]    RdData;
  logic          Busy;
  logic [7:0]    TX_P_Data;
  logic          TX_D_VLD;
  logic          CLK_div_en;
  logic          ALU_PEND;
  logic          RD_PEND;
  logic          OVF_ALU;
  logic          OVF_RD;
  logic          TX_DONE;

  tx_resp_arbiter #(
    .DATA_WIDTH   (DW),
    .BUSY_TIMEOUT (BT),
    .ALU_FIRST    (1'b1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .ALU_OUT     (ALU_OUT),
    .RdData_VLD  (RdData_VLD),
    .RdData      (RdData),
    .Busy        (Busy),
    .TX_P_Data   (TX_P_Data),
    .TX_D_VLD    (TX_D_VLD),
    .CLK_div_en  (CLK_div_en),
    .ALU_PEND    (ALU_PEND),
    .RD_PEND     (RD_PEND),
    .OVF_ALU     (OVF_ALU),
    .OVF_RD      (OVF_RD),
    .TX_DONE     (TX_DONE)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         busy_cnt = 0;
  bit         model_en = 1'b1;
  int         n_vld = 0, n_done = 0, n_ovf_rd = 0, n_ovf_alu = 0, vld_busy = 0;
  logic [7:0] txq[$];
  int         tstamp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model and monitor: Busy rises on the negedge a byte is seen, holds BUSY_LEN cycles.
  always @(negedge CLK) begin
    cyc++;
    if (TX_D_VLD === 1'b1) begin
      if (Busy) vld_busy++;
      txq.push_back(TX_P_Data);
      tstamp.push_back(cyc);
      n_vld++;
    end
    if (TX_DONE === 1'b1) n_done++;
    if (OVF_RD === 1'b1)  n_ovf_rd++;
    if (OVF_ALU === 1'b1) n_ovf_alu++;
    if (busy_cnt > 0) busy_cnt--;
    if (TX_D_VLD === 1'b1 && model_en) busy_cnt = BUSY_LEN;
    Busy = (busy_cnt != 0);
  end

  task automatic strobe(input logic a_v, input logic [15:0] a, input logic r_v, input logic [7:0] r);
    @(negedge CLK);
    ALU_OUT_VLD = a_v; ALU_OUT = a;
    RdData_VLD  = r_v; RdData  = r;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    RdData_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge CLK); #1;
      if (CLK_div_en == 1'b0 && !Busy) break;
    end
    if (i == max_cyc) chk("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge CLK);
    #1;
  endtask

  task automatic clear_log();
    txq.delete();
    tstamp.delete();
  endtask

  initial begin
    int done0, ovf0, base;
    RST = 1'b1; Busy = 1'b0;
    ALU_OUT_VLD = 1'b0; ALU_OUT = '0; RdData_VLD = 1'b0; RdData = '0;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_vld", 32'(TX_D_VLD), 32'd0);
    chk("rst_data", 32'(TX_P_Data), 32'h0);
    chk("rst_pend", 32'({ALU_PEND, RD_PEND}), 32'd0);
    chk("rst_pulses", 32'({OVF_ALU, OVF_RD, TX_DONE}), 32'd0);
    chk("rst_clken", 32'(CLK_div_en), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_clken", 32'(CLK_div_en), 32'd0);
    #1; clear_log(); done0 = n_done;

    // 1: single RdData byte, 3-cycle latency
    strobe(1'b0, 16'h0, 1'b1, 8'hA5);
    chk("t1_pend_set", 32'(RD_PEND), 32'd1);
    chk("t1_clken", 32'(CLK_div_en), 32'd1);
    @(negedge CLK);
    chk("t1_pend_clr", 32'(RD_PEND), 32'd0);
    chk("t1_vld_early", 32'(TX_D_VLD), 32'd0);
    @(negedge CLK);
    chk("t1_vld", 32'(TX_D_VLD), 32'd1);
    chk("t1_byte", 32'(TX_P_Data), 32'hA5);
    wait_idle(100);
    chk("t1_count", 32'(txq.size()), 32'd1);
    chk("t1_done", 32'(n_done - done0), 32'd1);

    // 2: ALU result, low byte first, second byte after Busy falls
    clear_log(); done0 = n_done;
    strobe(1'b1, 16'h1234, 1'b0, 8'h0);
    wait_idle(200);
    chk("t2_count", 32'(txq.size()), 32'd2);
    chk("t2_b0", 32'(txq[0]), 32'h34);
    chk("t2_b1", 32'(txq[1]), 32'h12);
    chk("t2_gap", 32'(tstamp[1] - tstamp[0]), 32'(BUSY_LEN + 2));
    chk("t2_done", 32'(n_done - done0), 32'd1);

    // 3: simultaneous strobes, priority rotates
    clear_log(); done0 = n_done;
    strobe(1'b1, 16'h1234, 1'b1, 8'hA5);
    wait_idle(300);
    chk("t3a_count", 32'(txq.size()), 32'd3);
    chk("t3a_b0", 32'(txq[0]), 32'h34);
    chk("t3a_b1", 32'(txq[1]), 32'h12);
    chk("t3a_b2", 32'(txq[2]), 32'hA5);
    chk("t3a_done", 32'(n_done - done0), 32'd2);
    clear_log();
    strobe(1'b1, 16'h1234, 1'b1, 8'hA5);
    wait_idle(300);
    chk("t3b_count", 32'(txq.size()), 32'd3);
    chk("t3b_b0", 32'(txq[0]), 32'hA5);
    chk("t3b_b1", 32'(txq[1]), 32'h34);
    chk("t3b_b2", 32'(txq[2]), 32'h12);

    // 4: RdData overflow while ALU transfer in progress
    clear_log(); ovf0 = n_ovf_rd;
    strobe(1'b1, 16'hABCD, 1'b0, 8'h0);
    @(negedge CLK);
    RdData_VLD = 1'b1; RdData = 8'h11;
    @(negedge CLK);
    RdData = 8'h22;
    @(negedge CLK);
    RdData_VLD = 1'b0;
    wait_idle(300);
    chk("t4_count", 32'(txq.size()), 32'd3);
    chk("t4_b0", 32'(txq[0]), 32'hCD);
    chk("t4_b1", 32'(txq[1]), 32'hAB);
    chk("t4_b2", 32'(txq[2]), 32'h11);
    chk("t4_ovf_rd", 32'(n_ovf_rd - ovf0), 32'd1);
    chk("t4_ovf_alu", 32'(n_ovf_alu), 32'd0);

    // 5: Busy never rises -> re-issue every BT+1 cycles, then release
    clear_log(); done0 = n_done; base = n_vld;
    model_en = 1'b0;
    strobe(1'b0, 16'h0, 1'b1, 8'h5A);
    for (int i = 0; i < 100 && n_vld < base + 3; i++) begin
      @(negedge CLK); #1;
    end
    chk("t5_reissue", 32'(n_vld - base), 32'd3);
    model_en = 1'b1;
    wait_idle(200);
    chk("t5_count", 32'(txq.size()), 32'd4);
    chk("t5_gap1", 32'(tstamp[1] - tstamp[0]), 32'(BT + 1));
    chk("t5_gap2", 32'(tstamp[2] - tstamp[1]), 32'(BT + 1));
    chk("t5_gap3", 32'(tstamp[3] - tstamp[2]), 32'(BT + 1));
    chk("t5_same", 32'({txq[0], txq[3]}), 32'h5A5A);
    chk("t5_done", 32'(n_done - done0), 32'd1);

    // 6: reset during WAIT_LO of the first ALU byte
    clear_log(); done0 = n_done;
    strobe(1'b1, 16'hBEEF, 1'b0, 8'h0);
    for (int i = 0; i < 50 && !Busy; i++) begin
      @(negedge CLK); #1;
    end
    chk("t6_busy_seen", 32'(Busy), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_vld", 32'(TX_D_VLD), 32'd0);
    chk("t6_data", 32'(TX_P_Data), 32'h0);
    chk("t6_pend", 32'({ALU_PEND, RD_PEND}), 32'd0);
    chk("t6_pulses", 32'({OVF_ALU, OVF_RD, TX_DONE}), 32'd0);
    chk("t6_clken_rst", 32'(CLK_div_en), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("t6_clken", 32'(CLK_div_en), 32'd0);
    wait_idle(100);
    chk("t6_abandon", 32'(txq.size()), 32'd1);
    chk("t6_b0", 32'(txq[0]), 32'hEF);
    chk("t6_nodone", 32'(n_done - done0), 32'd0);
    strobe(1'b0, 16'h0, 1'b1, 8'h77);
    wait_idle(100);
    chk("t6_after", 32'(txq.size()), 32'd2);
    chk("t6_b1", 32'(txq[1]), 32'h77);
    chk("t6_done", 32'(n_done - done0), 32'd1);

    chk("vld_while_busy", 32'(vld_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

endmodule
